// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
//   - FSM state encoding (ST_IDLE, ST_RUN, ST_FIX)
//   - is_legal_op / is_div helpers used when an operation is accepted
package mdu_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) ||
           (op == OP_DIVU)  || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate.
//   in_i  [W-1:0]  value
//   neg_i          1 = output -in_i, 0 = pass through
//   out_o [W-1:0]  result
// Used both to turn signed operands into magnitudes and to re-apply the
// sign to the unsigned product / quotient / remainder.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multicycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, op[2:0]      launch request and opcode (sampled only when idle)
//   op_a, op_b          multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wdata direct HI/LO writes (MTHI/MTLO), idle only
//   busy                operation in flight (RUN and FIX states)
//   done                one-cycle pulse, HI/LO hold the new result
//   div_by_zero         sticky flag from the last DIV/DIVU
//   hi, lo              architectural HI/LO registers
//   zf                  hi==0 && lo==0
//   dbg_state           current FSM state (mdu_pkg::state_t encoding)
//
// Handshake: a request is taken on a rising edge where busy=0, start=1 and
// op is legal. busy then stays high for WIDTH+1 cycles (WIDTH RUN
// iterations plus the FIX cycle); done pulses in the first cycle after,
// when busy is already low, so a new start may be presented in that same
// cycle. start while busy=1 is dropped, not queued.
//
// Build option: MDU_SIGNED_EN enables signed MULT/DIV. Without it the
// sign-conditioning logic is absent and MULT/DIV behave as MULTU/DIVU.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t state_q, state_d;

  // FSM-decoded controls
  logic ld_en;    // accept a new operation this cycle
  logic iter_en;  // one shift-add / restoring-divide step
  logic fix_en;   // sign fix and HI/LO write-back

  // Datapath state.
  // mult: {acc_q[W-1:0], sr_q} is the growing product, mcand_q = |op_a|
  // div : acc_q is the W+1 bit partial remainder, sr_q shifts dividend
  //       bits out at the top and quotient bits in at the bottom,
  //       mcand_q = |op_b| (divisor)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res;

  logic [WIDTH:0] prod_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  // ---------------------------------------------------------------------
  // Sign conditioning
  // ---------------------------------------------------------------------
`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_res_q, neg_rem_q;

  assign a_neg = op[0] & op_a[WIDTH-1];
  assign b_neg = op[0] & op_b[WIDTH-1];

  // Product/quotient sign is the XOR of operand signs; the remainder
  // follows the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (ld_en) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end
  end

  mdu_sign_fix #(.W(WIDTH)) u_mag_a (
    .in_i (op_a), .neg_i(a_neg), .out_o(mag_a)
  );
  mdu_sign_fix #(.W(WIDTH)) u_mag_b (
    .in_i (op_b), .neg_i(b_neg), .out_o(mag_b)
  );
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .in_i ({acc_q[WIDTH-1:0], sr_q}), .neg_i(neg_res_q), .out_o(prod_res)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
    .in_i (sr_q), .neg_i(neg_res_q), .out_o(quot_res)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .in_i (acc_q[WIDTH-1:0]), .neg_i(neg_rem_q), .out_o(rem_res)
  );
`else
  assign mag_a    = op_a;
  assign mag_b    = op_b;
  assign prod_res = {acc_q[WIDTH-1:0], sr_q};
  assign quot_res = sr_q;
  assign rem_res  = acc_q[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && is_legal_op(op)) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = 1'b0;
    ld_en   = 1'b0;
    iter_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      ST_IDLE: ld_en = start && is_legal_op(op);
      ST_RUN: begin
        busy    = 1'b1;
        iter_en = 1'b1;
      end
      ST_FIX: begin
        busy   = 1'b1;
        fix_en = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iteration arithmetic
  // ---------------------------------------------------------------------
  // Shift-add: add the multiplicand when the current multiplier LSB is set;
  // the carry becomes the new top bit after the right shift.
  assign prod_sum = {1'b0, acc_q[WIDTH-1:0]} +
                    (sr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  // Restoring divide: bring down the next dividend bit and trial-subtract.
  // The partial remainder is always < divisor, so the shifted value fits
  // in W+1 bits and the compare stands in for the borrow.
  assign div_shift = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  assign div_diff  = div_shift - {1'b0, mcand_q};

  // ---------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    mcand_d    = mcand_q;
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;
    done_d     = fix_en;
    hi_d       = hi_q;
    lo_d       = lo_q;

    // Direct writes only while idle; may coincide with an accepted start.
    if (!busy) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    if (ld_en) begin
      cnt_d      = '0;
      acc_d      = '0;
      div_d      = is_div(op);
      mcand_d    = is_div(op) ? mag_b : mag_a;
      sr_d       = is_div(op) ? mag_a : mag_b;
      dbz_pend_d = is_div(op) && (op_b == '0);
      if (is_div(op) && (op_b != '0)) dbz_d = 1'b0;
    end

    if (iter_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        acc_d = div_ge ? div_diff : div_shift;
        sr_d  = {sr_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = {1'b0, prod_sum[WIDTH:1]};
        sr_d  = {prod_sum[0], sr_q[WIDTH-1:1]};
      end
    end

    if (fix_en) begin
      if (div_q) begin
        // A zero divisor naturally leaves remainder = |dividend|; the
        // quotient is forced to all ones regardless of sign correction.
        lo_d  = dbz_pend_q ? '1 : quot_res;
        hi_d  = rem_res;
        dbz_d = dbz_pend_q;
      end else begin
        hi_d = prod_res[2*WIDTH-1:WIDTH];
        lo_d = prod_res[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= 1'b0;
      acc_q      <= '0;
      sr_q       <= '0;
      mcand_q    <= '0;
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      mcand_q    <= mcand_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zf          = (hi_q == '0) && (lo_q == '0);
  assign dbg_state   = state_q;

endmodule
